// File: rtl/rv_pkg.sv
// Shared RV32I core definitions.
// Register index type and architectural constants.
package rv_pkg;

  localparam int XLEN      = 32;
  localparam int REG_IDX_W = 5;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  localparam reg_idx_t REG_ZERO = 5'd0;

endpackage

// File: rtl/rf_bypass_mux.sv
// One register-file read port.
// Forces x0 to zero and optionally forwards the in-flight WB write.
module rf_bypass_mux
  import rv_pkg::*;
#(
  parameter int W      = 32,
  parameter bit BYPASS = 1'b1
) (
  input  reg_idx_t       rs,
  input  reg_idx_t       rd,
  input  logic           wr_en,
  input  logic [W-1:0]   wdata,
  input  logic [W-1:0]   stored,
  output logic [W-1:0]   rdata
);

  logic hit;

  assign hit = BYPASS && wr_en && (rs == rd);

  always_comb begin
    rdata = stored;
    unique case (1'b1)
      (rs == REG_ZERO): rdata = '0;
      hit:              rdata = wdata;
      default:          rdata = stored;
    endcase
  end

endmodule

// File: rtl/reg_file.sv
// RV32I integer register file with WB->ID bypass.
// Also keeps a retired-write counter and a registered debug port.
module reg_file
  import rv_pkg::*;
#(
  parameter int XLEN   = rv_pkg::XLEN,
  parameter int NREGS  = 32,
  parameter bit BYPASS = 1'b1,
  parameter int CNT_W  = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wb_regwrite,
  input  reg_idx_t         wb_rd,
  input  logic [XLEN-1:0]  wb_wdata,
  input  reg_idx_t         id_rs1,
  input  reg_idx_t         id_rs2,
  output logic [XLEN-1:0]  id_rdata1,
  output logic [XLEN-1:0]  id_rdata2,
  input  reg_idx_t         dbg_idx,
  output logic [XLEN-1:0]  dbg_rdata,
  output logic [CNT_W-1:0] wr_count,
  output logic             wr_pulse
);

  logic [XLEN-1:0] regs [1:NREGS-1];
  logic            wr_en;
  logic [XLEN-1:0] stored1;
  logic [XLEN-1:0] stored2;
  logic [XLEN-1:0] stored_dbg;

  // x0 has no storage; indices past NREGS read as zero
  function automatic logic [XLEN-1:0] rd_reg(input reg_idx_t idx);
    logic [XLEN-1:0] v;
    v = '0;
    if (idx != REG_ZERO && int'(idx) < NREGS)
      v = regs[idx];
    return v;
  endfunction

  assign wr_en = wb_regwrite && (wb_rd != REG_ZERO)
              && (int'(wb_rd) < NREGS);

  assign stored1    = rd_reg(id_rs1);
  assign stored2    = rd_reg(id_rs2);
  assign stored_dbg = rd_reg(dbg_idx);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < NREGS; i++)
        regs[i] <= '0;
    end else if (wr_en) begin
      regs[wb_rd] <= wb_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dbg_rdata <= '0;
      wr_count  <= '0;
      wr_pulse  <= 1'b0;
    end else begin
      dbg_rdata <= stored_dbg;
      wr_pulse  <= wr_en;
      if (wr_en)
        wr_count <= wr_count + CNT_W'(1);
    end
  end

  rf_bypass_mux #(.W(XLEN), .BYPASS(BYPASS)) u_rd1 (
    .rs     (id_rs1),
    .rd     (wb_rd),
    .wr_en  (wr_en),
    .wdata  (wb_wdata),
    .stored (stored1),
    .rdata  (id_rdata1)
  );

  rf_bypass_mux #(.W(XLEN), .BYPASS(BYPASS)) u_rd2 (
    .rs     (id_rs2),
    .rd     (wb_rd),
    .wr_en  (wr_en),
    .wdata  (wb_wdata),
    .stored (stored2),
    .rdata  (id_rdata2)
  );

endmodule

// File: tb/tb_reg_file.sv
// Scoreboard bench for reg_file: bypass, no-bypass and 4-bit counter builds.
// Stimulus queues expectations; a negedge monitor drains and compares.
module tb_reg_file;

  localparam int K_R1   = 0;
  localparam int K_R2   = 1;
  localparam int K_R1NB = 2;
  localparam int K_R2NB = 3;
  localparam int K_DBG  = 4;
  localparam int K_CNT  = 5;
  localparam int K_PUL  = 6;
  localparam int K_CNT4 = 7;

  typedef struct {
    int          kind;
    logic [31:0] exp;
    string       name;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wb_regwrite = 1'b0;
  logic [4:0]  wb_rd = '0;
  logic [31:0] wb_wdata = '0;
  logic [4:0]  id_rs1 = '0;
  logic [4:0]  id_rs2 = '0;
  logic [4:0]  dbg_idx = '0;

  logic [31:0] r1, r2, dbg;
  logic [31:0] cnt;
  logic        pul;
  logic [31:0] r1_nb, r2_nb, dbg_nb, cnt_nb;
  logic        pul_nb;
  logic [31:0] r1_c4, r2_c4, dbg_c4;
  logic [3:0]  cnt_c4;
  logic        pul_c4;

  exp_t        q[$];
  int          n_chk = 0;
  int          n_fail = 0;

  logic [31:0] m [32];
  logic [31:0] mdbg;
  logic [31:0] mcnt;
  logic        mpul;

  always #5 clk = ~clk;

  reg_file u_dut (
    .clk(clk), .rst_n(rst_n), .wb_regwrite(wb_regwrite),
    .wb_rd(wb_rd), .wb_wdata(wb_wdata),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rdata1(r1), .id_rdata2(r2),
    .dbg_idx(dbg_idx), .dbg_rdata(dbg),
    .wr_count(cnt), .wr_pulse(pul)
  );

  reg_file #(.BYPASS(1'b0)) u_nb (
    .clk(clk), .rst_n(rst_n), .wb_regwrite(wb_regwrite),
    .wb_rd(wb_rd), .wb_wdata(wb_wdata),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rdata1(r1_nb), .id_rdata2(r2_nb),
    .dbg_idx(dbg_idx), .dbg_rdata(dbg_nb),
    .wr_count(cnt_nb), .wr_pulse(pul_nb)
  );

  reg_file #(.CNT_W(4)) u_c4 (
    .clk(clk), .rst_n(rst_n), .wb_regwrite(wb_regwrite),
    .wb_rd(wb_rd), .wb_wdata(wb_wdata),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rdata1(r1_c4), .id_rdata2(r2_c4),
    .dbg_idx(dbg_idx), .dbg_rdata(dbg_c4),
    .wr_count(cnt_c4), .wr_pulse(pul_c4)
  );

  // Monitor: compares every queued expectation at the sampling edge
  always @(negedge clk) begin
    exp_t        e;
    logic [31:0] act;
    while (q.size() > 0) begin
      e = q.pop_front();
      case (e.kind)
        K_R1:    act = r1;
        K_R2:    act = r2;
        K_R1NB:  act = r1_nb;
        K_R2NB:  act = r2_nb;
        K_DBG:   act = dbg;
        K_CNT:   act = cnt;
        K_PUL:   act = {31'd0, pul};
        K_CNT4:  act = {28'd0, cnt_c4};
        default: act = 'x;
      endcase
      n_chk++;
      if (act !== e.exp) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h at %0t",
                 e.name, act, e.exp, $time);
      end
    end
  end

  task automatic push(input int k, input logic [31:0] v,
                      input string nm);
    exp_t e;
    e.kind = k;
    e.exp  = v;
    e.name = nm;
    q.push_back(e);
  endtask

  task automatic clr_model();
    for (int i = 0; i < 32; i++) m[i] = '0;
    mdbg = '0;
    mcnt = '0;
    mpul = 1'b0;
  endtask

  function automatic logic [31:0] rd_byp(input logic eff,
      input logic [4:0] rs, input logic [4:0] rd,
      input logic [31:0] wd);
    if (rs == 0) return '0;
    if (eff && rs == rd) return wd;
    return m[rs];
  endfunction

  // One clock of stimulus; called at posedge+1
  task automatic cyc(input logic rw, input logic [4:0] rd,
                     input logic [31:0] wd, input logic [4:0] a,
                     input logic [4:0] b, input logic [4:0] d);
    logic eff;
    eff = rw && (rd != 0) && rst_n;
    wb_regwrite = rw;
    wb_rd       = rd;
    wb_wdata    = wd;
    id_rs1      = a;
    id_rs2      = b;
    dbg_idx     = d;
    push(K_R1,   rd_byp(eff, a, rd, wd), "rdata1");
    push(K_R2,   rd_byp(eff, b, rd, wd), "rdata2");
    push(K_R1NB, m[a], "rdata1_nobyp");
    push(K_R2NB, m[b], "rdata2_nobyp");
    push(K_DBG,  mdbg, "dbg_rdata");
    push(K_CNT,  mcnt, "wr_count");
    push(K_PUL,  {31'd0, mpul}, "wr_pulse");
    push(K_CNT4, {28'd0, mcnt[3:0]}, "wr_count4");
    @(posedge clk);
    #1;
    if (!rst_n) begin
      clr_model();
    end else begin
      mdbg = m[d];
      mpul = eff;
      if (eff) begin
        m[rd] = wd;
        mcnt  = mcnt + 1;
      end
    end
  endtask

  task automatic idle(input logic [4:0] a, input logic [4:0] b,
                      input logic [4:0] d);
    cyc(1'b0, 5'd3, 32'hA5A5A5A5, a, b, d);
  endtask

  task automatic reset_mid();
    wb_regwrite = 1'b1;
    wb_rd       = 5'd9;
    wb_wdata    = 32'hCAFEF00D;
    rst_n       = 1'b0;
    clr_model();
    push(K_CNT, 32'd0, "rst_cnt_async");
    push(K_DBG, 32'd0, "rst_dbg_async");
    push(K_PUL, 32'd0, "rst_pulse_async");
    push(K_R1,  32'd0, "rst_x5_async");
    cyc(1'b1, 5'd9, 32'hCAFEF00D, 5'd5, 5'd7, 5'd5);
    cyc(1'b0, 5'd0, 32'h0, 5'd9, 5'd1, 5'd9);
    rst_n = 1'b1;
  endtask

  initial begin
    clr_model();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset state
    push(K_CNT, 32'd0, "reset_cnt");
    idle(5'd1, 5'd31, 5'd1);

    // Write x5 and read it back next cycle
    cyc(1'b1, 5'd5, 32'hDEADBEEF, 5'd0, 5'd0, 5'd5);
    push(K_R1, 32'hDEADBEEF, "x5_read");
    push(K_CNT, 32'd1, "cnt_after_x5");
    push(K_PUL, 32'd1, "pulse_after_x5");
    push(K_DBG, 32'd0, "dbg_pre_write_x5");
    idle(5'd5, 5'd0, 5'd5);
    push(K_DBG, 32'hDEADBEEF, "dbg_x5");
    push(K_PUL, 32'd0, "pulse_drop");
    idle(5'd0, 5'd5, 5'd0);

    // Same-cycle bypass on both ports
    push(K_R1,   32'h12345678, "byp_rs1");
    push(K_R2,   32'h12345678, "byp_rs2");
    push(K_R1NB, 32'd0, "nobyp_rs1_old");
    push(K_R2NB, 32'd0, "nobyp_rs2_old");
    cyc(1'b1, 5'd7, 32'h12345678, 5'd7, 5'd7, 5'd7);
    push(K_R1NB, 32'h12345678, "nobyp_next");
    idle(5'd7, 5'd7, 5'd7);

    // x0 write discarded
    cyc(1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 5'd0);
    push(K_R1, 32'd0, "x0_read");
    push(K_CNT, 32'd2, "x0_cnt_hold");
    push(K_PUL, 32'd0, "x0_no_pulse");
    idle(5'd0, 5'd0, 5'd0);

    // Dont-care write data with regwrite low
    cyc(1'b0, 5'd5, 32'h0BADF00D, 5'd5, 5'd5, 5'd5);
    push(K_R1, 32'hDEADBEEF, "wen0_hold");
    idle(5'd5, 5'd0, 5'd0);

    // Reset mid-operation, pending x9 write lost
    reset_mid();
    push(K_R1, 32'd0, "x9_lost");
    push(K_CNT, 32'd0, "cnt_cleared");
    idle(5'd9, 5'd5, 5'd0);

    // Back-to-back fill of x1..x31
    for (int i = 1; i < 32; i++)
      cyc(1'b1, 5'(i), 32'(i) * 32'h01010101,
          5'(i - 1), 5'(i), 5'(i - 1));
    push(K_CNT, 32'd31, "fill_cnt31");
    push(K_PUL, 32'd1, "fill_pulse_last");
    push(K_CNT4, 32'd15, "fill_cnt4");
    for (int i = 1; i < 32; i++)
      idle(5'(i), 5'(32 - i), 5'(i));
    push(K_DBG, 32'h1F1F1F1F, "dbg_x31");
    push(K_PUL, 32'd0, "fill_pulse_end");
    idle(5'd0, 5'd0, 5'd0);

    // 4-bit counter wrap after 17 writes
    rst_n = 1'b0;
    clr_model();
    idle(5'd0, 5'd0, 5'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 17; i++)
      cyc(1'b1, 5'(1 + (i % 3)), 32'(i), 5'd1, 5'd2, 5'd3);
    push(K_CNT4, 32'd1, "cnt4_wrap");
    push(K_CNT, 32'd17, "cnt_17");
    idle(5'd1, 5'd2, 5'd3);
    push(K_CNT4, 32'd1, "cnt4_hold");
    push(K_R1, 32'd15, "x1_last");
    idle(5'd1, 5'd2, 5'd3);
    idle(5'd0, 5'd0, 5'd0);

    @(negedge clk);
    @(negedge clk);
    if (q.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
